// File: rtl/ysyx_22040383_pipe_stage_skid.sv
// ysyx_22040383_pipe_stage_skid
//
// Pipeline stage register that sits between two core stages (IF/ID, ID/EX, ...).
// It carries an opaque payload under a valid/ready handshake. When SKID_EN=1 it
// holds up to two entries (main + skid), so in_ready comes straight from a flop.
// When SKID_EN=0 it is a single entry, and in_ready is combinational.
// A flush empties the stage, and a saturating counter records downstream stalls.
//
// Handshake: a transfer happens on a posedge where valid & ready are both 1.
// A producer holds valid and data stable until that transfer. Ready may be
// asserted with or without valid. out_data is all-zero whenever out_valid=0.
//
// Parameters
//   DATA_W   payload width in bits
//   SKID_EN  1: two-entry stage with registered in_ready; 0: one-entry stage
//   CNT_W    width of stall_cnt
// Ports
//   sys_clk    clock, all state changes on posedge
//   sys_rst    synchronous active-high reset
//   flush      drop every held entry and the payload offered this cycle
//   in_valid   upstream offers in_data
//   in_ready   stage accepts a payload this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a live payload
//   out_ready  downstream consumes out_data this cycle
//   out_data   payload to downstream, zero when out_valid=0
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
module ysyx_22040383_pipe_stage_skid #(
  parameter int DATA_W  = 160,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Occupancy: EMPTY (mv=0,sv=0), ONE (mv=1,sv=0), TWO (mv=1,sv=1).
  // TWO is only reachable when SKID_EN=1.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] md_q, md_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic              acc;
  logic              pop;

  assign out_valid = (state_q != ST_EMPTY);
  // md is cleared whenever the stage drains, so it is already zero while empty.
  assign out_data  = md_q;

  always_comb begin
    if (SKID_EN) begin
      in_ready = (state_q != ST_TWO);
    end else begin
      in_ready = (state_q == ST_EMPTY) | out_ready;
    end
  end

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    md_d    = md_q;
    sd_d    = sd_q;
    if (flush) begin
      // The payload offered in the flush cycle is discarded as well.
      state_d = ST_EMPTY;
      md_d    = '0;
      sd_d    = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            md_d    = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            md_d = in_data;
          end else if (acc && !pop && SKID_EN) begin
            sd_d    = in_data;
            state_d = ST_TWO;
          end else if (!acc && pop) begin
            md_d    = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so nothing new can arrive.
          if (pop) begin
            md_d    = sd_q;
            sd_d    = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          md_d    = '0;
          sd_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_EMPTY;
      md_q    <= '0;
      sd_q    <= '0;
    end else begin
      state_q <= state_d;
      md_q    <= md_d;
      sd_q    <= sd_d;
    end
  end

  // Counts every cycle that downstream back-pressures a live payload,
  // including a flush cycle. Only reset clears it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_22040383_pipe_stage_skid.sv
module tb_ysyx_22040383_pipe_stage_skid;

  logic clk;
  logic rst;

  // Instance a: default parameters (two-entry stage, 160-bit payload)
  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [159:0] a_in_data, a_out_data;
  logic [31:0]  a_stall_cnt;
  // Instance b: single-entry stage
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0]  b_in_data, b_out_data;
  logic [31:0]  b_stall_cnt;
  // Instance c: narrow counter for saturation
  logic         c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0]   c_in_data, c_out_data;
  logic [3:0]   c_stall_cnt;

  int pass_cnt;
  int total_cnt;
  logic [159:0] exp_q[$];

  ysyx_22040383_pipe_stage_skid u_a (
    .sys_clk(clk), .sys_rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stall_cnt(a_stall_cnt)
  );

  ysyx_22040383_pipe_stage_skid #(.DATA_W(16), .SKID_EN(1'b0), .CNT_W(32)) u_b (
    .sys_clk(clk), .sys_rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall_cnt(b_stall_cnt)
  );

  ysyx_22040383_pipe_stage_skid #(.DATA_W(8), .SKID_EN(1'b1), .CNT_W(4)) u_c (
    .sys_clk(clk), .sys_rst(rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .stall_cnt(c_stall_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_flush = 0; b_flush = 0; c_flush = 0;
    a_in_valid = 1; b_in_valid = 1; c_in_valid = 1;
    a_in_data = 160'hdead; b_in_data = 16'hbeef; c_in_data = 8'h77;
    a_out_ready = 0; b_out_ready = 0; c_out_ready = 0;
    tick();
    tick();
    chk("reset_a_out_valid", 160'(a_out_valid), 160'd0);
    chk("reset_a_out_data", a_out_data, 160'd0);
    chk("reset_a_in_ready", 160'(a_in_ready), 160'd1);
    chk("reset_a_stall_cnt", 160'(a_stall_cnt), 160'd0);
    chk("reset_b_out_valid", 160'(b_out_valid), 160'd0);
    chk("reset_c_stall_cnt", 160'(c_stall_cnt), 160'd0);
    rst = 1'b0;
    a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
    a_in_data = '0; b_in_data = '0; c_in_data = '0;
  endtask

  task automatic test_streaming();
    a_out_ready = 1;
    for (int i = 1; i <= 6; i++) begin
      a_in_valid = 1;
      a_in_data  = 160'(i);
      exp_q.push_back(160'(i));
      #1;
      chk("stream_in_ready", 160'(a_in_ready), 160'd1);
      tick();
      chk("stream_out_valid", 160'(a_out_valid), 160'd1);
      chk("stream_out_data", a_out_data, exp_q.pop_front());
    end
    a_in_valid = 0;
    a_in_data  = '0;
    tick();
    chk("stream_drain_valid", 160'(a_out_valid), 160'd0);
    chk("stream_drain_data", a_out_data, 160'd0);
    chk("stream_stall_cnt", 160'(a_stall_cnt), 160'd0);
  endtask

  task automatic test_back_pressure();
    logic [159:0] pa, pb;
    pa = {64'h0000_0000_8000_0000, 64'h0000_0000_8000_0004, 32'h0000_0013};
    pb = {64'h0000_0000_8000_0004, 64'h0000_0000_8000_0008, 32'h00a0_0093};
    a_out_ready = 0;
    a_in_valid  = 1;
    a_in_data   = pa;
    tick();
    chk("bp_one_valid", 160'(a_out_valid), 160'd1);
    chk("bp_one_data", a_out_data, pa);
    chk("bp_one_in_ready", 160'(a_in_ready), 160'd1);
    a_in_data = pb;
    tick();
    chk("bp_two_in_ready", 160'(a_in_ready), 160'd0);
    chk("bp_two_data", a_out_data, pa);
    chk("bp_two_cnt", 160'(a_stall_cnt), 160'd1);
    a_in_valid = 0;
    a_in_data  = '0;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_hold_data", a_out_data, pa);
    chk("bp_hold_cnt", 160'(a_stall_cnt), 160'd4);
    a_out_ready = 1;
    tick();
    chk("bp_rel_valid", 160'(a_out_valid), 160'd1);
    chk("bp_rel_data_b", a_out_data, pb);
    chk("bp_rel_in_ready", 160'(a_in_ready), 160'd1);
    chk("bp_rel_cnt", 160'(a_stall_cnt), 160'd4);
    tick();
    chk("bp_empty_valid", 160'(a_out_valid), 160'd0);
    chk("bp_empty_data", a_out_data, 160'd0);
  endtask

  task automatic test_flush();
    a_out_ready = 0;
    a_in_valid  = 1;
    a_in_data   = 160'h1111;
    tick();
    a_in_data = 160'h2222;
    tick();
    chk("flush_pre_in_ready", 160'(a_in_ready), 160'd0);
    a_in_data = 160'hcccc;
    a_flush   = 1;
    tick();
    chk("flush_out_valid", 160'(a_out_valid), 160'd0);
    chk("flush_out_data", a_out_data, 160'd0);
    chk("flush_in_ready", 160'(a_in_ready), 160'd1);
    chk("flush_cnt", 160'(a_stall_cnt), 160'd6);
    a_flush     = 0;
    a_in_valid  = 0;
    a_in_data   = '0;
    a_out_ready = 1;
    tick();
    tick();
    chk("flush_no_c_valid", 160'(a_out_valid), 160'd0);
    chk("flush_no_c_data", a_out_data, 160'd0);
  endtask

  task automatic test_no_skid();
    b_out_ready = 0;
    b_in_valid  = 1;
    b_in_data   = 16'h0011;
    #1;
    chk("ns_empty_in_ready", 160'(b_in_ready), 160'd1);
    tick();
    chk("ns_m_data", 160'(b_out_data), 160'h11);
    b_in_data = 16'h0022;
    #1;
    chk("ns_full_in_ready", 160'(b_in_ready), 160'd0);
    tick();
    chk("ns_held_data", 160'(b_out_data), 160'h11);
    b_out_ready = 1;
    #1;
    chk("ns_pass_in_ready", 160'(b_in_ready), 160'd1);
    tick();
    chk("ns_pass_valid", 160'(b_out_valid), 160'd1);
    chk("ns_pass_data", 160'(b_out_data), 160'h22);
    b_in_valid = 0;
    b_in_data  = '0;
    tick();
    chk("ns_drain_valid", 160'(b_out_valid), 160'd0);
    chk("ns_drain_data", 160'(b_out_data), 160'd0);
    chk("ns_stall_cnt", 160'(b_stall_cnt), 160'd1);
  endtask

  task automatic test_saturation();
    c_out_ready = 0;
    c_in_valid  = 1;
    c_in_data   = 8'h5a;
    tick();
    c_in_valid = 0;
    c_in_data  = '0;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_cnt_10", 160'(c_stall_cnt), 160'd10);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_cnt_max", 160'(c_stall_cnt), 160'd15);
    chk("sat_data", 160'(c_out_data), 160'h5a);
    rst = 1;
    tick();
    rst = 0;
    chk("sat_reset_cnt", 160'(c_stall_cnt), 160'd0);
    chk("sat_reset_valid", 160'(c_out_valid), 160'd0);
    chk("sat_reset_a_cnt", 160'(a_stall_cnt), 160'd0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_no_skid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
